// File: rtl/brisc_pkg.sv
// Shared decode types for the brisc pipeline: instruction formats, opcode map
// and the decoded bundle carried from decode into register-read/execute.
package brisc_pkg;

    localparam int PKG_XLEN  = 32;
    localparam int PKG_ILEN  = 32;
    localparam int PKG_NREGS = 32;
    localparam int PKG_RB    = $clog2(PKG_NREGS);

    typedef enum logic [2:0] {
        IT_R       = 3'd0,
        IT_I       = 3'd1,
        IT_S       = 3'd2,
        IT_B       = 3'd3,
        IT_U       = 3'd4,
        IT_J       = 3'd5,
        IT_INVALID = 3'd6
    } itype_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef struct packed {
        logic [PKG_XLEN-1:0] pc;
        logic [6:0]          opcode;
        itype_e              itype;
        logic [PKG_RB-1:0]   rs1;
        logic [PKG_RB-1:0]   rs2;
        logic [PKG_RB-1:0]   rd;
        logic [2:0]          funct3;
        logic [6:0]          funct7;
        logic [PKG_XLEN-1:0] imm;
        logic                illegal;
    } decoded_t;

    // Every valid opcode ends in 2'b11, so a bad length field lands in INVALID.
    function automatic itype_e classify(input logic [6:0] opc);
        case (opc)
            OPC_OP:                                        return IT_R;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM:    return IT_I;
            OPC_STORE:                                     return IT_S;
            OPC_BRANCH:                                    return IT_B;
            OPC_LUI, OPC_AUIPC:                            return IT_U;
            OPC_JAL:                                       return IT_J;
            default:                                       return IT_INVALID;
        endcase
    endfunction

endpackage

// File: rtl/idecode_comb.sv
// Combinational instruction decoder: classifies the opcode and extracts
// register indices, funct fields and the sign-extended immediate.
module idecode_comb
    import brisc_pkg::*;
(
    input  logic [PKG_ILEN-1:0] instr,
    input  logic [PKG_XLEN-1:0] pc,
    output decoded_t            dec
);

    itype_e      itype;
    logic [31:0] imm32;

    assign itype = classify(instr[6:0]);

    always_comb begin
        imm32 = 32'd0;
        case (itype)
            IT_I:    imm32 = {{20{instr[31]}}, instr[31:20]};
            IT_S:    imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IT_B:    imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IT_U:    imm32 = {instr[31:12], 12'd0};
            IT_J:    imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = 32'd0;
        endcase
    end

    always_comb begin
        dec         = '0;
        dec.pc      = pc;
        dec.opcode  = instr[6:0];
        dec.itype   = itype;
        dec.illegal = (itype == IT_INVALID);
        dec.imm     = PKG_XLEN'(signed'(imm32));
        // Fields are only populated where the format actually defines them.
        if (itype inside {IT_R, IT_I, IT_S, IT_B}) begin
            dec.rs1    = instr[19:15];
            dec.funct3 = instr[14:12];
        end
        if (itype inside {IT_R, IT_S, IT_B}) dec.rs2 = instr[24:20];
        if (itype inside {IT_R, IT_I, IT_U, IT_J}) dec.rd = instr[11:7];
        if (itype == IT_R) dec.funct7 = instr[31:25];
    end

endmodule

// File: rtl/idecode_stage.sv
// Registered decode stage with valid/ready on both sides, an optional skid
// register for full throughput, and a flush that kills everything held.
module idecode_stage
    import brisc_pkg::*;
#(
    parameter int XLEN    = PKG_XLEN,
    parameter int ILEN    = PKG_ILEN,
    parameter int NREGS   = PKG_NREGS,
    parameter int RB      = $clog2(NREGS),
    parameter bit SKID_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [ILEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_itype,
    output logic [RB-1:0]   out_rs1,
    output logic [RB-1:0]   out_rs2,
    output logic [RB-1:0]   out_rd,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; a producer holds its data stable until that edge.
    decoded_t dec, out_q, skid_q;
    logic     out_valid_q, skid_valid_q, in_ready_q;
    logic     accept, out_free;

    idecode_comb u_comb (
        .instr (in_instr),
        .pc    (in_pc),
        .dec   (dec)
    );

    assign out_free = !out_valid_q || out_ready;
    assign in_ready = SKID_EN ? in_ready_q : out_free;
    assign accept   = in_valid && in_ready && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else if (out_free) begin
            // The skid entry is older than anything on the input, so it goes first.
            if (skid_valid_q) begin
                out_q        <= skid_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else begin
                if (accept) out_q <= dec;
                out_valid_q <= accept;
            end
            in_ready_q <= 1'b1;
        end else if (accept) begin
            skid_q       <= dec;
            skid_valid_q <= 1'b1;
            in_ready_q   <= 1'b0;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_pc      = out_q.pc;
    assign out_opcode  = out_q.opcode;
    assign out_itype   = out_q.itype;
    assign out_rs1     = out_q.rs1;
    assign out_rs2     = out_q.rs2;
    assign out_rd      = out_q.rd;
    assign out_funct3  = out_q.funct3;
    assign out_funct7  = out_q.funct7;
    assign out_imm     = out_q.imm;
    assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_idecode_stage.sv
// Bench for idecode_stage: directed decode cases, skid/flush/reset scenarios
// and a random valid/ready soak, all checked against a queue of expected bundles.
module tb_idecode_stage;
  localparam int W = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [6:0]  out_opcode;
  logic [2:0]  out_itype;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [31:0] out_imm;
  logic        out_illegal;

  int n_cmp = 0;
  int n_err = 0;
  int n_out = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] prev_bundle;
  bit           prev_stall = 0;

  idecode_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_itype(out_itype), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_rd(out_rd), .out_funct3(out_funct3),
    .out_funct7(out_funct7), .out_imm(out_imm), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode: itype codes R=0 I=1 S=2 B=3 U=4 J=5 INVALID=6.
  function automatic logic [W-1:0] model(input logic [31:0] i, input logic [31:0] pc);
    logic [2:0] it; logic [4:0] rs1, rs2, rd; logic [2:0] f3; logic [6:0] f7;
    logic [31:0] imm; logic ill;
    it = 3'd6; rs1 = 0; rs2 = 0; rd = 0; f3 = 0; f7 = 0; imm = 0; ill = 0;
    case (i[6:0])
      7'h33: begin it = 0; rs1 = i[19:15]; rs2 = i[24:20]; rd = i[11:7]; f3 = i[14:12]; f7 = i[31:25]; end
      7'h13, 7'h03, 7'h67, 7'h73: begin
        it = 1; rs1 = i[19:15]; rd = i[11:7]; f3 = i[14:12];
        imm = {{20{i[31]}}, i[31:20]};
      end
      7'h23: begin
        it = 2; rs1 = i[19:15]; rs2 = i[24:20]; f3 = i[14:12];
        imm = {{20{i[31]}}, i[31:25], i[11:7]};
      end
      7'h63: begin
        it = 3; rs1 = i[19:15]; rs2 = i[24:20]; f3 = i[14:12];
        imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      end
      7'h37, 7'h17: begin it = 4; rd = i[11:7]; imm = {i[31:12], 12'h000}; end
      7'h6F: begin it = 5; rd = i[11:7]; imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0}; end
      default: ill = 1;
    endcase
    return {pc, i[6:0], it, rs1, rs2, rd, f3, f7, imm, ill};
  endfunction

  function automatic logic [W-1:0] cur_bundle();
    return {out_pc, out_opcode, out_itype, out_rs1, out_rs2, out_rd,
            out_funct3, out_funct7, out_imm, out_illegal};
  endfunction

  // Scoreboard: held entries == queue length, so out_valid/in_ready follow from it.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      prev_stall = 0;
    end else begin
      check("out_valid", out_valid, exp_q.size() != 0);
      check("in_ready", in_ready, exp_q.size() < 2);
      if (prev_stall) check("hold", cur_bundle(), prev_bundle);
      if (flush) begin
        exp_q.delete();
        prev_stall = 0;
      end else begin
        if (out_valid && out_ready) begin
          n_out++;
          if (exp_q.size() > 0) check("bundle", cur_bundle(), exp_q.pop_front());
        end
        if (in_valid && in_ready) exp_q.push_back(model(in_instr, in_pc));
        prev_stall  = out_valid && !out_ready;
        prev_bundle = cur_bundle();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_instr(input logic [31:0] ins, input logic [31:0] pc);
    bit fired = 0;
    in_valid = 1; in_instr = ins; in_pc = pc;
    for (int t = 0; t < 20 && !fired; t++) begin
      @(negedge clk);
      fired = in_ready && !flush;
      tick();
    end
    in_valid = 0;
    if (!fired) check("push_timeout", 0, 1);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] opcs[11];
    logic [31:0] r;
    opcs = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h0B};
    r = $urandom();
    if ($urandom_range(0, 7) != 0) r[6:0] = opcs[$urandom_range(0, 10)];
    return r;
  endfunction

  initial begin
    logic [31:0] stream_tbl[4];
    bit fired, saw_low;
    int k, base_out;

    repeat (2) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_imm", out_imm, 0);
    reset = 0;
    tick();

    // Directed decode cases
    out_ready = 1;
    push_instr(32'h00A30293, 32'h1000);
    check("addi_valid", out_valid, 1);
    check("addi_itype", out_itype, 1);
    check("addi_rd", out_rd, 5);
    check("addi_rs1", out_rs1, 6);
    check("addi_imm", out_imm, 10);
    push_instr(32'hFE0008E3, 32'h1004);
    check("beq_itype", out_itype, 3);
    check("beq_imm", out_imm, 32'hFFFFFFF0);
    check("beq_rd", out_rd, 0);
    push_instr(32'h800000EF, 32'h1008);
    check("jal_itype", out_itype, 5);
    check("jal_imm", out_imm, 32'hFFF00000);
    check("jal_rd", out_rd, 1);
    push_instr(32'h12345037, 32'h100C);
    check("lui_itype", out_itype, 4);
    check("lui_imm", out_imm, 32'h12345000);
    push_instr(32'hFFFFFFFF, 32'h1010);
    check("inv_itype", out_itype, 6);
    check("inv_illegal", out_illegal, 1);
    check("inv_fields", {out_rs1, out_rs2, out_rd, out_funct3, out_funct7, out_imm}, 0);
    repeat (2) tick();

    // Stream of 4 with the consumer stalled on cycles 2-3
    stream_tbl = '{32'h00B50533, 32'h00112423, 32'h0000A0B7, 32'hFFC10113};
    k = 0; saw_low = 0; base_out = n_out;
    for (int cyc = 0; cyc < 30 && (k < 4 || out_valid); cyc++) begin
      out_ready = !(cyc == 2 || cyc == 3);
      in_valid = (k < 4);
      in_instr = stream_tbl[k % 4];
      in_pc = 32'h2000 + 4 * k;
      @(negedge clk);
      fired = in_valid && in_ready;
      if (!in_ready) saw_low = 1;
      tick();
      if (fired) k++;
    end
    in_valid = 0; out_ready = 1;
    tick();
    check("stream_in_ready_dropped", saw_low, 1);
    check("stream_emitted", n_out - base_out, 4);

    // Fill output + skid, then flush with a simultaneous in_valid
    out_ready = 0;
    push_instr(32'h00000013, 32'h3000);
    push_instr(32'h00100093, 32'h3004);
    check("skid_full_in_ready", in_ready, 0);
    flush = 1; in_valid = 1; in_instr = 32'h00200113; in_pc = 32'h3008; out_ready = 1;
    tick();
    flush = 0; in_valid = 0;
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    base_out = n_out;
    repeat (3) tick();
    check("flush_nothing_emitted", n_out - base_out, 0);

    // Async reset between edges while instructions are held
    out_ready = 0;
    push_instr(32'h00300193, 32'h4000);
    push_instr(32'h00400213, 32'h4004);
    #2 reset = 1;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_in_ready", in_ready, 1);
    tick();
    reset = 0;
    tick();

    // Random soak with occasional flush
    in_valid = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!in_valid || fired) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_instr = rand_instr();
        in_pc = $urandom();
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 40) == 0);
      @(negedge clk);
      fired = in_valid && in_ready && !flush;
      tick();
    end
    flush = 0; in_valid = 0; out_ready = 1;
    repeat (4) tick();
    check("drain_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
